// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, waits out the ROM latency, and hands {pc, inst}
// to decode under a valid/allow handshake. Exception redirect beats branch redirect beats pc+4.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ROM_LAT  = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ID_allow_in,
   input  logic [32:0] jbr_bus,
   input  logic [32:0] exc_bus,
   output logic [31:0] inst_addr,
   input  logic [31:0] inst,
   output logic        IF_over,
   output logic [63:0] IF_ID_bus,
   output logic [31:0] IF_pc,
   output logic [31:0] IF_inst
);

   typedef enum logic {
      WAIT  = 1'b0,
      READY = 1'b1
   } state_t;

   localparam logic [2:0] CNT_LAST = 3'(ROM_LAT - 1);

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [2:0]  cnt, cnt_nxt;
   logic [31:0] inst_r, inst_r_nxt;
   logic        br_pend, br_pend_nxt;
   logic [31:0] br_target, br_target_nxt;

   logic        jbr_taken;
   logic [31:0] jbr_target;
   logic        exc_valid;
   logic [31:0] exc_pc;
   logic        transfer;
   logic [31:0] next_pc;

   assign jbr_taken  = jbr_bus[32];
   assign jbr_target = jbr_bus[31:0];
   assign exc_valid  = exc_bus[32];
   assign exc_pc     = exc_bus[31:0];

   assign transfer = (state == READY) && ID_allow_in && !exc_valid;

   // A live branch wins over one captured earlier; pc+4 wraps naturally at 2^32.
   assign next_pc = jbr_taken ? jbr_target :
                    br_pend   ? br_target  :
                                pc + 32'd4;

   // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
   always_comb begin
      state_nxt     = state;
      pc_nxt        = pc;
      cnt_nxt       = cnt;
      inst_r_nxt    = inst_r;
      br_pend_nxt   = br_pend;
      br_target_nxt = br_target;

      if (exc_valid) begin
         pc_nxt      = exc_pc;
         state_nxt   = WAIT;
         cnt_nxt     = 3'd0;
         br_pend_nxt = 1'b0;
      end else begin
         unique case (state)
            WAIT: begin
               if (cnt == CNT_LAST) begin
                  inst_r_nxt = inst;
                  state_nxt  = READY;
                  cnt_nxt    = 3'd0;
               end else begin
                  cnt_nxt = cnt + 3'd1;
               end
            end
            READY: begin
               if (ID_allow_in) begin
                  pc_nxt      = next_pc;
                  state_nxt   = WAIT;
                  cnt_nxt     = 3'd0;
                  br_pend_nxt = 1'b0;
               end
            end
         endcase

         // A branch that cannot be taken this cycle is remembered until the next transfer.
         if (jbr_taken && !transfer) begin
            br_pend_nxt   = 1'b1;
            br_target_nxt = jbr_target;
         end
      end
   end

   // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= WAIT;
         pc        <= RESET_PC;
         cnt       <= 3'd0;
         inst_r    <= 32'd0;
         br_pend   <= 1'b0;
         br_target <= 32'd0;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         cnt       <= cnt_nxt;
         inst_r    <= inst_r_nxt;
         br_pend   <= br_pend_nxt;
         br_target <= br_target_nxt;
      end
   end

   assign inst_addr = pc;
   assign IF_over   = (state == READY) && !exc_valid;
   assign IF_ID_bus = {pc, inst_r};
   assign IF_pc     = pc;
   assign IF_inst   = inst_r;

endmodule
